// File: rtl/intc_pkg.sv
// Shared types and defaults for the external interrupt controller.
// Optional input synchronizer is selected with the INTC_SYNC_EN macro.
package intc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } intc_state_t;

   localparam int DEF_N_IRQ       = 8;
   localparam int DEF_ACK_TIMEOUT = 3;

   // Width of an irq index; never zero so a 1-bit port always exists.
   function automatic int irq_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IRQ_ID_W = irq_id_w(DEF_N_IRQ);

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational lowest-index priority encoder over the enabled pending set.
module intc_prio_enc
   import intc_pkg::*;
#(
   parameter int N = DEF_N_IRQ,
   parameter int W = irq_id_w(DEF_N_IRQ)
) (
   input  logic [N-1:0] cand,
   output logic         valid,
   output logic [W-1:0] id
);

   // Scan downward so the lowest set index is the last assignment.
   always_comb begin
      valid = |cand;
      id    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (cand[i]) id = W'(i);
      end
   end

endmodule

// File: rtl/intr_controller.sv
// External interrupt collector: edge detect, pending/mask, lowest-index select,
// one-cycle registered request pulse and single in-flight service tracking.
// Define INTC_SYNC_EN to put a two-flop synchronizer on every irq_in bit.
module intr_controller
   import intc_pkg::*;
#(
   parameter int N_IRQ       = DEF_N_IRQ,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_IRQ-1:0]           irq_in,
   input  logic                       exe_intr,
   input  logic                       INTS_end,
   input  logic                       mask_we,
   input  logic [N_IRQ-1:0]           mask_wdata,
   output logic                       External_intr,
   output logic [irq_id_w(N_IRQ)-1:0] irq_id,
   output logic [N_IRQ-1:0]           pending,
   output logic [N_IRQ-1:0]           mask
);

   localparam int ID_W  = irq_id_w(N_IRQ);
   localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

   intc_state_t        state;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [N_IRQ-1:0]   irq_s, irq_q, rise, cand;
   logic [N_IRQ-1:0]   pend_set, pend_clr;
   logic               cand_valid;
   logic [ID_W-1:0]    cand_id;
   logic               accept, timeout;

`ifdef INTC_SYNC_EN
   logic [N_IRQ-1:0] irq_m;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_m <= '0;
         irq_s <= '0;
      end else begin
         irq_m <= irq_in;
         irq_s <= irq_m;
      end
   end
`else
   assign irq_s = irq_in;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_q <= '0;
      else        irq_q <= irq_s;
   end

   assign rise = irq_s & ~irq_q;
   assign cand = pending & mask;

   intc_prio_enc #(.N(N_IRQ), .W(ID_W)) u_prio_enc (
      .cand  (cand),
      .valid (cand_valid),
      .id    (cand_id)
   );

   assign accept  = (state == IDLE) && cand_valid && !exe_intr;
   assign timeout = (state == REQ) && !exe_intr && (tmo_cnt == TMO_LAST);

   // Set terms are applied after the clear so a same-cycle rise keeps the bit.
   always_comb begin
      pend_clr = '0;
      pend_set = rise;
      if (accept)  pend_clr[cand_id] = 1'b1;
      if (timeout) pend_set[irq_id]  = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         mask    <= '1;
      end else begin
         pending <= (pending & ~pend_clr) | pend_set;
         if (mask_we) mask <= mask_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         tmo_cnt       <= '0;
         External_intr <= 1'b0;
         irq_id        <= '0;
      end else begin
         External_intr <= accept;
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (accept) begin
                  irq_id <= cand_id;
                  state  <= REQ;
               end
            end
            REQ: begin
               if (exe_intr) begin
                  tmo_cnt <= '0;
                  state   <= SERVICE;
               end else if (timeout) begin
                  tmo_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            SERVICE: begin
               tmo_cnt <= '0;
               if (INTS_end) state <= IDLE;
            end
            default: begin
               tmo_cnt <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intr_controller.sv
// Directed bench for intr_controller: expected irq_id values go into a queue,
// a negedge monitor pops one for every External_intr pulse.
module tb_intr_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irq_in;
   logic       exe_intr;
   logic       INTS_end;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic       External_intr;
   logic [2:0] irq_id;
   logic [7:0] pending;
   logic [7:0] mask;

   logic [2:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         pulse_cnt = 0;
   logic       prev_pulse = 1'b0;
   int         n;

   intr_controller #(.N_IRQ(8), .ACK_TIMEOUT(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .irq_in        (irq_in),
      .exe_intr      (exe_intr),
      .INTS_end      (INTS_end),
      .mask_we       (mask_we),
      .mask_wdata    (mask_wdata),
      .External_intr (External_intr),
      .irq_id        (irq_id),
      .pending       (pending),
      .mask          (mask)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (External_intr) begin
               pulse_cnt++;
               check("pulse_width", {31'd0, prev_pulse}, 32'd0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pulse: got irq_id %0d expected no pulse", irq_id);
               end else begin
                  check("irq_id", {29'd0, irq_id}, {29'd0, exp_q.pop_front()});
               end
            end
            prev_pulse = External_intr;
         end else begin
            prev_pulse = 1'b0;
         end
      end
   end

   // driver tasks
   task automatic tick(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_pulse(input int max_cycles, output int cnt);
      logic found;
      found = 1'b0;
      cnt   = 0;
      while (!found && cnt < max_cycles) begin
         @(posedge clk);
         #1;
         cnt++;
         if (External_intr) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL pulse_timeout: got no pulse expected one within %0d cycles", max_cycles);
      end
   endtask

   task automatic serve();
      exe_intr = 1'b1;
      tick(2);
      exe_intr = 1'b0;
      INTS_end = 1'b1;
      tick(1);
      INTS_end = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      irq_in     = '0;
      exe_intr   = 1'b0;
      INTS_end   = 1'b0;
      mask_we    = 1'b0;
      mask_wdata = '0;
      tick(2);
      check("rst_ext_intr", {31'd0, External_intr}, 32'd0);
      check("rst_irq_id",   {29'd0, irq_id},        32'd0);
      check("rst_pending",  {24'd0, pending},       32'h00);
      check("rst_mask",     {24'd0, mask},          32'hFF);
      rst_n = 1'b1;
      tick(2);

      // single source, ack one cycle after the pulse
      irq_in = 8'h08;
      exp_q.push_back(3'd3);
      tick(1);
      check("t1_pending_set", {24'd0, pending}, 32'h08);
      check("t1_no_early_pulse", {31'd0, External_intr}, 32'd0);
      wait_pulse(4, n);
      check("t1_latency", n, 32'd1);
      check("t1_pending_clr", {24'd0, pending}, 32'h00);
      serve();
      irq_in = '0;
      check("t1_irq_id_held", {29'd0, irq_id}, 32'd3);
      check("t1_pulse_cnt", pulse_cnt, 32'd1);

      // two simultaneous sources, lowest index first
      irq_in = 8'h24;
      exp_q.push_back(3'd2);
      exp_q.push_back(3'd5);
      wait_pulse(4, n);
      check("t2_latency", n, 32'd2);
      check("t2_pending_rest", {24'd0, pending}, 32'h20);
      serve();
      wait_pulse(4, n);
      check("t2_min_spacing", n, 32'd1);
      check("t2_pending_clr", {24'd0, pending}, 32'h00);
      serve();
      irq_in = '0;

      // masked source latches pending, fires after unmask
      mask_we    = 1'b1;
      mask_wdata = 8'hF7;
      tick(1);
      mask_we = 1'b0;
      check("t3_mask_f7", {24'd0, mask}, 32'hF7);
      irq_in = 8'h08;
      tick(4);
      check("t3_masked_pending", {24'd0, pending}, 32'h08);
      check("t3_no_pulse", pulse_cnt, 32'd3);
      mask_we    = 1'b1;
      mask_wdata = 8'hFF;
      exp_q.push_back(3'd3);
      wait_pulse(4, n);
      mask_we = 1'b0;
      check("t3_unmask_latency", n, 32'd2);
      check("t3_mask_ff", {24'd0, mask}, 32'hFF);
      serve();
      irq_in = '0;

      // exe_intr held high blocks the accept
      exe_intr = 1'b1;
      irq_in   = 8'h01;
      tick(5);
      check("t4_held_pending", {24'd0, pending}, 32'h01);
      check("t4_no_pulse", pulse_cnt, 32'd4);
      exe_intr = 1'b0;
      exp_q.push_back(3'd0);
      wait_pulse(3, n);
      check("t4_release_latency", n, 32'd1);
      serve();
      irq_in = '0;

      // new rise on the bit being accepted keeps it pending
      exe_intr = 1'b1;
      irq_in   = 8'h08;
      tick(1);
      irq_in = 8'h00;
      tick(1);
      irq_in   = 8'h08;
      exe_intr = 1'b0;
      exp_q.push_back(3'd3);
      wait_pulse(3, n);
      check("t4b_latency", n, 32'd1);
      check("t4b_rise_wins", {24'd0, pending}, 32'h08);
      serve();
      exp_q.push_back(3'd3);
      wait_pulse(3, n);
      check("t4b_second_latency", n, 32'd1);
      check("t4b_pending_clr", {24'd0, pending}, 32'h00);
      serve();
      irq_in = '0;

      // no acknowledge: timeout re-pends and re-issues
      irq_in = 8'h02;
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd1);
      wait_pulse(4, n);
      check("t5_latency", n, 32'd2);
      check("t5_pending_clr", {24'd0, pending}, 32'h00);
      tick(3);
      check("t5_repended", {24'd0, pending}, 32'h02);
      check("t5_no_pulse_yet", {31'd0, External_intr}, 32'd0);
      wait_pulse(3, n);
      check("t5_repulse_latency", n, 32'd1);
      serve();
      irq_in = '0;

      // asynchronous reset during SERVICE
      irq_in = 8'h04;
      exp_q.push_back(3'd2);
      wait_pulse(4, n);
      check("t6_latency", n, 32'd2);
      exe_intr = 1'b1;
      tick(1);
      irq_in = 8'h15;
      tick(1);
      mask_we    = 1'b1;
      mask_wdata = 8'h0F;
      tick(1);
      mask_we = 1'b0;
      check("t6_pending_11", {24'd0, pending}, 32'h11);
      check("t6_mask_0f", {24'd0, mask}, 32'h0F);
      check("t6_no_pulse_service", {31'd0, External_intr}, 32'd0);
      rst_n = 1'b0;
      #2;
      check("t6_rst_ext_intr", {31'd0, External_intr}, 32'd0);
      check("t6_rst_irq_id",   {29'd0, irq_id},        32'd0);
      check("t6_rst_pending",  {24'd0, pending},       32'h00);
      check("t6_rst_mask",     {24'd0, mask},          32'hFF);
      irq_in   = '0;
      exe_intr = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(4);
      check("t6_no_pulse_after_rst", pulse_cnt, 32'd10);
      check("exp_q_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/intr_controller.md
# intr_controller

Upstream interrupt controller for the pipelined MIPS core. Collects N external interrupt lines, edge-detects and latches them as pending, applies a software-writable enable mask, selects the lowest-numbered enabled pending source, and issues a single glitch-free `External_intr` pulse to the interrupt unit. It then tracks that service (`exe_intr` … `INTS_end`) so only one external interrupt is in flight at a time.

## Interface
- `N_IRQ`, 8, number of external request lines (2..16)
- `ACK_TIMEOUT`, 3, cycles to wait for `exe_intr` after a pulse before re-pending
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `irq_in`  in  N_IRQ  raw request lines, rising-edge sensitive
- `exe_intr`  in  1  interrupt unit is executing a service routine
- `INTS_end`  in  1  one-cycle end-of-service strobe (eret)
- `mask_we`  in  1  write strobe for mask register
- `mask_wdata`  in  N_IRQ  new mask, 1 = source enabled
- `External_intr`  out  1  registered one-cycle request pulse to interrupt unit
- `irq_id`  out  $clog2(N_IRQ)  index of accepted source, held until next accept
- `pending`  out  N_IRQ  pending register
- `mask`  out  N_IRQ  current mask register

## Operation
- Reset values: `External_intr`=0, `irq_id`=0, `pending`=0, `mask`=all ones, edge-history regs=0, state=IDLE, timeout counter=0.
- Edge detect: `rise = irq_s & ~irq_q`, where `irq_q` is `irq_s` delayed one cycle; `pending |= rise` every cycle.
- Mask: on `mask_we`, `mask <= mask_wdata` at clock edge. Masked sources still latch pending.
- `cand = pending & mask`; winner = lowest set index.
- FSM:
  - IDLE: if `cand != 0` and `exe_intr == 0`, then assert `External_intr` next cycle, load `irq_id` with winner, clear winner's pending bit, go REQ. If `exe_intr == 1` (e.g. overflow service), hold.
  - REQ: if `exe_intr == 1`, go SERVICE. Otherwise increment timeout counter. At `ACK_TIMEOUT`, re-set `pending[irq_id]` and go IDLE.
  - SERVICE: on `INTS_end == 1`, go IDLE. Never pulse here.
- `External_intr` is high for exactly one cycle per accept and comes straight from a flop. Downstream uses it as an asynchronous set, so it must not glitch.
- Simultaneous events:
  - A new rise on the bit being cleared by accept wins: the bit stays pending.
  - A mask write in the accept cycle does not affect the current selection, which uses the old mask.
  - `INTS_end` in IDLE or REQ is ignored.
- Reset mid-operation returns everything to reset values immediately. Pending requests are lost.

## Timing
- Without sync: rise on `irq_in` sampled at edge k sets `pending` at k. `External_intr` is high in cycle k+1 when IDLE, `cand` enabled, and `exe_intr` low.
- With sync: add 2 cycles.
- Minimum spacing between two pulses: pulse cycle, ≥1 SERVICE cycle, `INTS_end`, 1 IDLE cycle.
- REQ→SERVICE is taken on the first cycle `exe_intr` is seen high. Normally this is the cycle after the pulse.

## Configuration
- `INTC_SYNC_EN` defined: each `irq_in` bit passes through a two-flop synchronizer (reset 0) before edge detect, which adds 2 cycles of latency.
- Not defined: `irq_in` is treated as synchronous to `clk` and fed directly to edge detect.

## Structure
- Package `intc_pkg`:
  - state enum `intc_state_t` {IDLE, REQ, SERVICE}
  - default `N_IRQ`, `ACK_TIMEOUT`
  - `IRQ_ID_W` function/constant
- Sub-module `intc_prio_enc`: combinational lowest-index priority encoder. Inputs: `cand`. Outputs: `valid`, `id`.

## Test plan
- Reset, then `irq_in[3]` rises, `exe_intr` follows pulse by 1 cycle → one `External_intr` pulse, `irq_id`=3, `pending[3]`=0; `INTS_end` → IDLE.
- `irq_in[5]` and `irq_in[2]` rise in the same cycle → first pulse `irq_id`=2. After `INTS_end`, second pulse `irq_id`=5.
- `mask`=8'hF7, `irq_in[3]` rises → no pulse and `pending[3]`=1. Write `mask`=8'hFF → pulse with `irq_id`=3 on the cycle after the write.
- `exe_intr` held high (overflow service) when `irq_in[0]` rises → no pulse until `exe_intr` drops, then pulse `irq_id`=0.
- Pulse issued, `exe_intr` never rises → after `ACK_TIMEOUT`=3 cycles `pending[irq_id]` is re-set and a new pulse follows.
- Assert `rst_n`=0 during SERVICE with `pending`=8'h11 → all outputs return to reset values asynchronously and `mask`=8'hFF.
